// File: rtl/div_pkg.sv
// Shared definitions for the restoring divider: FSM state encoding and default operand width.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/trial_subtractor.sv
// Ripple subtractor a - b built from full-adder cells (inverted subtrahend, carry-in 1).
// borrow is the inverse of the final carry out.
module trial_subtractor #(
    parameter int N = 9
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff,
    output logic         borrow
);

    logic [N:0] carry;

    assign carry[0] = 1'b1;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_fa
            logic b_inv;
            assign b_inv         = ~b[gi];
            assign diff[gi]      = a[gi] ^ b_inv ^ carry[gi];
            assign carry[gi + 1] = (a[gi] & b_inv) | (carry[gi] & (a[gi] ^ b_inv));
        end
    endgenerate

    assign borrow = ~carry[N];

endmodule

// File: rtl/restoring_divider.sv
// Sequential unsigned restoring divider: one quotient bit per RUN cycle, WIDTH RUN cycles,
// followed by a single DONE cycle that pulses done. Divide-by-zero short-circuits to DONE.
module restoring_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] dvd_reg;        // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0] dvs_reg;
    logic [WIDTH:0]   rem_reg;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] quotient_reg;
    logic [WIDTH-1:0] remainder_reg;
    logic             dbz_reg;

    logic             accept;
    logic             last;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             borrow;
    logic             keep;
    logic [WIDTH:0]   rem_next;
    logic [WIDTH-1:0] dvd_next;

    assign shifted = {rem_reg[WIDTH-1:0], dvd_reg[WIDTH-1]};

    trial_subtractor #(
        .N(WIDTH + 1)
    ) u_trial_subtractor (
        .a     (shifted),
        .b     ({1'b0, dvs_reg}),
        .diff  (diff),
        .borrow(borrow)
    );

    // A set top bit in the partial remainder would make the shifted value exceed any divisor;
    // the restoring invariant keeps it zero, but honouring it keeps the datapath exact.
    assign keep     = ~borrow | rem_reg[WIDTH];
    assign rem_next = keep ? diff : shifted;
    assign dvd_next = {dvd_reg[WIDTH-2:0], keep};
    assign last     = (cnt_reg == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = (divisor == '0) ? DONE : RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            RUN: begin
                if (last) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd_reg       <= '0;
            dvs_reg       <= '0;
            rem_reg       <= '0;
            cnt_reg       <= '0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            dbz_reg       <= 1'b0;
        end else if (accept) begin
            dvd_reg <= dividend;
            dvs_reg <= divisor;
            rem_reg <= '0;
            cnt_reg <= CW'(WIDTH - 1);
            if (divisor == '0) begin
                quotient_reg  <= '1;
                remainder_reg <= dividend;
                dbz_reg       <= 1'b1;
            end
        end else if (state_reg == RUN) begin
            rem_reg <= rem_next;
            dvd_reg <= dvd_next;
            if (last) begin
                quotient_reg  <= dvd_next;
                remainder_reg <= rem_next[WIDTH-1:0];
                dbz_reg       <= 1'b0;
            end else begin
                cnt_reg <= cnt_reg - CW'(1);
            end
        end
    end

    assign busy        = (state_reg == RUN);
    assign done        = (state_reg == DONE);
    assign quotient    = quotient_reg;
    assign remainder   = remainder_reg;
    assign div_by_zero = dbz_reg;

endmodule

// File: tb/tb_restoring_divider.sv
// Directed and random checks of restoring_divider (WIDTH=8): latency, results, ignored start,
// back-to-back start, divide-by-zero, and reset abort. Cycle n = interval after the n-th edge.
module tb_restoring_divider;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int n_checks = 0;
    int n_pass   = 0;

    restoring_divider #(
        .WIDTH(W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Caller sits at the negedge of cycle 'from'; returns the cycle in which done is seen.
    task automatic wait_done(input int from, output int lat);
        lat = from;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!done) check("done_timeout", {31'd0, done}, 32'd1);
    endtask

    // Issues a start, returns at the negedge of cycle 1.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input int exp_lat, input logic [W-1:0] exp_q, input logic [W-1:0] exp_r,
                           input logic exp_z);
        int lat;
        issue(a, b);
        wait_done(1, lat);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_q"}, quotient, exp_q);
        check({tag, "_r"}, remainder, exp_r);
        check({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, exp_z});
        $display("%s: %0d / %0d -> q=%0d r=%0d dbz=%0d lat=%0d", tag, a, b, quotient, remainder,
                 div_by_zero, lat);
    endtask

    initial begin
        int lat;
        int done_seen;
        logic [W-1:0] ra, rb;

        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        rst_n    = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_q", quotient, 32'd0);
        check("rst_r", remainder, 32'd0);
        check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
        rst_n = 1'b1;

        run_div("d100_7", 8'd100, 8'd7, 9, 8'd14, 8'd2, 1'b0);
        run_div("d255_1", 8'd255, 8'd1, 9, 8'd255, 8'd0, 1'b0);
        run_div("d5_9", 8'd5, 8'd9, 9, 8'd0, 8'd5, 1'b0);
        run_div("d200_0", 8'd200, 8'd0, 1, 8'hFF, 8'd200, 1'b1);

        repeat (3) @(negedge clk);
        check("hold_q", quotient, 32'd255);
        check("hold_dbz", {31'd0, div_by_zero}, 32'd1);
        check("idle_done", {31'd0, done}, 32'd0);

        // Start during RUN must be ignored.
        issue(8'd100, 8'd7);
        check("run_busy", {31'd0, busy}, 32'd1);
        check("run_q_held", quotient, 32'd255);
        @(negedge clk);
        @(negedge clk);
        start    = 1'b1;
        dividend = 8'd50;
        divisor  = 8'd5;
        @(negedge clk);
        start = 1'b0;
        wait_done(4, lat);
        check("ign_lat", lat, 32'd9);
        check("ign_q", quotient, 32'd14);
        check("ign_r", remainder, 32'd2);
        $display("ignored-start: 100 / 7 -> q=%0d r=%0d lat=%0d", quotient, remainder, lat);

        // Back-to-back start in the DONE cycle.
        start    = 1'b1;
        dividend = 8'd81;
        divisor  = 8'd9;
        @(negedge clk);
        start = 1'b0;
        check("b2b_busy", {31'd0, busy}, 32'd1);
        check("b2b_nodone", {31'd0, done}, 32'd0);
        wait_done(1, lat);
        check("b2b_lat", lat, 32'd9);
        check("b2b_q", quotient, 32'd9);
        check("b2b_r", remainder, 32'd0);
        $display("back-to-back: 81 / 9 -> q=%0d r=%0d lat=%0d", quotient, remainder, lat);
        @(negedge clk);
        check("b2b_single", {31'd0, done}, 32'd0);

        // Reset in the middle of RUN aborts the division.
        issue(8'd100, 8'd7);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_q", quotient, 32'd0);
        check("abort_r", remainder, 32'd0);
        check("abort_dbz", {31'd0, div_by_zero}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        check("abort_no_done", done_seen, 32'd0);
        $display("reset-abort: done pulses after abort=%0d", done_seen);
        run_div("d17_4", 8'd17, 8'd4, 9, 8'd4, 8'd1, 1'b0);

        for (int i = 0; i < 1000; i++) begin
            ra = W'($urandom_range(0, 255));
            rb = W'($urandom_range(1, 255));
            issue(ra, rb);
            wait_done(1, lat);
            check("rnd_inv", 32'(quotient) * 32'(rb) + 32'(remainder), 32'(ra));
            check("rnd_rlt", {31'd0, (remainder < rb)}, 32'd1);
            check("rnd_dbz", {31'd0, div_by_zero}, 32'd0);
            $display("rnd %0d: %0d / %0d -> q=%0d r=%0d lat=%0d", i, ra, rb, quotient, remainder, lat);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
